// File: rtl/key_event_decoder.sv
// Keypad scanner receive side: edge-detects key presses, tracks the held key and
// queues one event per valid press in a small FIFO with sticky error flags.
module key_event_decoder #(
    parameter int NKEYS = 20,
    parameter int CW    = 5,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       strobe,
    input  logic [CW-1:0]              code,
    input  logic                       clr_flags,
    input  logic                       ev_ready,
    output logic                       ev_valid,
    output logic [CW-1:0]              ev_code,
    output logic [NKEYS-1:0]           ev_onehot,
    output logic [NKEYS-1:0]           held,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       bad_code
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]      FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [NKEYS-1:0] ONE_HOT0 = NKEYS'(1);

    // Handshake: an event transfers on every cycle where ev_valid & ev_ready are both
    // high; ev_valid never depends on ev_ready and the head stays stable until taken.

    logic              strobe_q;
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [CW-1:0]     mem [DEPTH];

    logic press;
    logic release_ev;
    logic code_ok;
    logic push_req;
    logic full;
    logic pop;
    logic push;
    logic drop;

    always_comb begin
        press      = strobe & ~strobe_q;
        release_ev = strobe_q & ~strobe;
        code_ok    = (32'(code) < NKEYS);
        push_req   = press & code_ok;
        count      = wr_ptr - rd_ptr;
        full       = (count == FULL_CNT);
        ev_valid   = (count != '0);
        pop        = ev_valid & ev_ready;
        // A full FIFO still accepts a press when the head leaves in the same cycle.
        push       = push_req & (~full | pop);
        drop       = push_req & full & ~pop;
    end

    always_comb begin
        ev_code   = mem[rd_ptr[AW-1:0]];
        ev_onehot = '0;
        if (ev_valid) begin
            ev_onehot = ONE_HOT0 << ev_code;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            strobe_q <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            held     <= '0;
            overflow <= 1'b0;
            bad_code <= 1'b0;
        end else begin
            strobe_q <= strobe;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // held follows valid presses even when the event itself is dropped.
            if (push_req) begin
                held <= ONE_HOT0 << code;
            end else if (release_ev) begin
                held <= '0;
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_flags) begin
                overflow <= 1'b0;
            end
            if (press & ~code_ok) begin
                bad_code <= 1'b1;
            end else if (clr_flags) begin
                bad_code <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= code;
        end
    end

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed bench for key_event_decoder: reset, press/hold/release, repeat press,
// bad codes, overflow and the full-plus-pop corner, with an expected-event queue.
module tb_key_event_decoder;

    localparam int NKEYS = 20;
    localparam int CW    = 5;
    localparam int DEPTH = 4;

    logic              clk;
    logic              rst;
    logic              strobe;
    logic [CW-1:0]     code;
    logic              clr_flags;
    logic              ev_ready;
    logic              ev_valid;
    logic [CW-1:0]     ev_code;
    logic [NKEYS-1:0]  ev_onehot;
    logic [NKEYS-1:0]  held;
    logic [$clog2(DEPTH):0] count;
    logic              overflow;
    logic              bad_code;

    int total = 0;
    int bad   = 0;
    logic [CW-1:0] exp_q[$];

    key_event_decoder #(.NKEYS(NKEYS), .CW(CW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .strobe(strobe), .code(code), .clr_flags(clr_flags),
        .ev_ready(ev_ready), .ev_valid(ev_valid), .ev_code(ev_code), .ev_onehot(ev_onehot),
        .held(held), .count(count), .overflow(overflow), .bad_code(bad_code)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // advance one clock, settle just after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press_release(input logic [CW-1:0] c);
        strobe = 1'b1;
        code   = c;
        step();
        if (32'(c) < NKEYS) exp_q.push_back(c);
        strobe = 1'b0;
        step();
    endtask

    task automatic drain(input string tag);
        ev_ready = 1'b1;
        while (exp_q.size() > 0) begin
            logic [CW-1:0] e;
            e = exp_q.pop_front();
            check({tag, "_valid"}, 32'(ev_valid), 32'd1);
            check({tag, "_code"}, 32'(ev_code), 32'(e));
            check({tag, "_onehot"}, 32'(ev_onehot), 32'd1 << e);
            step();
        end
        ev_ready = 1'b0;
        check({tag, "_empty"}, 32'(ev_valid), 32'd0);
        check({tag, "_cnt0"}, 32'(count), 32'd0);
    endtask

    initial begin
        rst = 1'b0; strobe = 1'b1; code = 5'd7; clr_flags = 1'b0; ev_ready = 1'b0;

        // 1: reset with a key held, released before reset ends
        step(); step();
        check("rst_valid", 32'(ev_valid), 32'd0);
        check("rst_held", 32'(held), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_bad", 32'(bad_code), 32'd0);
        check("rst_onehot", 32'(ev_onehot), 32'd0);
        strobe = 1'b0;
        step();
        rst = 1'b1;
        repeat (3) step();
        check("rst_noevent", 32'(ev_valid), 32'd0);

        // 2: single press of key 5, held 10 cycles
        strobe = 1'b1; code = 5'd5;
        step();
        check("p5_valid", 32'(ev_valid), 32'd1);
        check("p5_code", 32'(ev_code), 32'd5);
        check("p5_onehot", 32'(ev_onehot), 32'h00020);
        check("p5_held", 32'(held), 32'h00020);
        repeat (9) step();
        check("p5_noretrig", 32'(count), 32'd1);
        check("p5_held_hold", 32'(held), 32'h00020);
        ev_ready = 1'b1;
        step();
        ev_ready = 1'b0;
        check("p5_popped", 32'(count), 32'd0);
        strobe = 1'b0;
        step();
        check("p5_release", 32'(held), 32'd0);
        check("p5_once", 32'(ev_valid), 32'd0);

        // 3: key 19 pressed twice, consumer always ready
        ev_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            strobe = 1'b1; code = 5'd19;
            step();
            check("p19_valid", 32'(ev_valid), 32'd1);
            check("p19_onehot", 32'(ev_onehot), 32'h80000);
            check("p19_held", 32'(held), 32'h80000);
            step();
            check("p19_taken", 32'(ev_valid), 32'd0);
            check("p19_held2", 32'(held), 32'h80000);
            strobe = 1'b0;
            step();
            check("p19_rel", 32'(held), 32'd0);
        end
        ev_ready = 1'b0;

        // 4: invalid code, clear, then set wins over a simultaneous clear
        strobe = 1'b1; code = 5'd25;
        step();
        check("bad_flag", 32'(bad_code), 32'd1);
        check("bad_noev", 32'(ev_valid), 32'd0);
        check("bad_held", 32'(held), 32'd0);
        strobe = 1'b0;
        step();
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
        check("bad_clr", 32'(bad_code), 32'd0);
        strobe = 1'b1; code = 5'd31; clr_flags = 1'b1;
        step();
        clr_flags = 1'b0; strobe = 1'b0;
        check("bad_setwins", 32'(bad_code), 32'd1);
        step();

        // 5: overflow with consumer stalled; last press coincides with clr_flags
        press_release(5'd1);
        press_release(5'd2);
        press_release(5'd3);
        press_release(5'd4);
        check("ovf_full", 32'(count), 32'd4);
        check("ovf_notyet", 32'(overflow), 32'd0);
        strobe = 1'b1; code = 5'd6; clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_count", 32'(count), 32'd4);
        check("ovf_held", 32'(held), 32'h00040);
        check("ovf_head", 32'(ev_code), 32'd1);
        strobe = 1'b0;
        step();
        drain("ovf");
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
        check("ovf_clr", 32'(overflow), 32'd0);
        check("ovf_clr_bad", 32'(bad_code), 32'd0);

        // empty FIFO ignores ev_ready
        ev_ready = 1'b1;
        step(); step();
        check("empty_cnt", 32'(count), 32'd0);
        ev_ready = 1'b0;

        // 6: full FIFO, press with a simultaneous pop
        press_release(5'd10);
        press_release(5'd11);
        press_release(5'd12);
        press_release(5'd13);
        check("fp_full", 32'(count), 32'd4);
        void'(exp_q.pop_front());
        strobe = 1'b1; code = 5'd9; ev_ready = 1'b1;
        step();
        exp_q.push_back(5'd9);
        ev_ready = 1'b0; strobe = 1'b0;
        check("fp_count", 32'(count), 32'd4);
        check("fp_ovf", 32'(overflow), 32'd0);
        check("fp_head", 32'(ev_code), 32'd11);
        step();
        drain("fp");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
